rab_arbiter: RTL

RAB_ARBITER -- requirements
Module: rab_arbiter

---
 rtl/rab_arbiter_if.sv | 45 ++++
 rtl/rab_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/rab_arbiter_if.sv
// Bus bundle between two RAB requesters (port 0: I2C slave, port 1: MCU),
// the arbiter and the shared RAB target.
interface rab_arbiter_if;
  logic [8:0] req0_addr;
  logic [7:0] req0_wdata;
  logic       req0_write;
  logic       req0_read;
  logic [7:0] req0_rdata;
  logic       req0_ack;

  logic [8:0] req1_addr;
  logic [7:0] req1_wdata;
  logic       req1_write;
  logic       req1_read;
  logic [7:0] req1_rdata;
  logic       req1_ack;

  logic [8:0] tgt_addr;
  logic [7:0] tgt_wdata;
  logic       tgt_write;
  logic       tgt_read;
  logic [7:0] tgt_rdata;
  logic       tgt_ack;

  logic       tout_err;
  logic       err_clr;

  // Arbiter side
  modport slave (
    input  req0_addr, req0_wdata, req0_write, req0_read,
    input  req1_addr, req1_wdata, req1_write, req1_read,
    input  tgt_rdata, tgt_ack, err_clr,
    output req0_rdata, req0_ack, req1_rdata, req1_ack,
    output tgt_addr, tgt_wdata, tgt_write, tgt_read, tout_err
  );

  // Requester / target environment side
  modport master (
    output req0_addr, req0_wdata, req0_write, req0_read,
    output req1_addr, req1_wdata, req1_write, req1_read,
    output tgt_rdata, tgt_ack, err_clr,
    input  req0_rdata, req0_ack, req1_rdata, req1_ack,
    input  tgt_addr, tgt_wdata, tgt_write, tgt_read, tout_err
  );
endinterface

// File: rtl/rab_arbiter.sv
// Two-port round-robin arbiter for a shared RAB target: latches one request per
// port, issues it as a single-cycle strobe and forces completion on timeout.
module rab_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  rab_arbiter_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  localparam logic [4:0] TMO = 5'(TIMEOUT);

  logic [1:0][8:0] in_addr;
  logic [1:0][7:0] in_wdata;
  logic [1:0]      in_rd;
  logic [1:0]      in_wr;

  state_t          state_q, state_d;
  logic [1:0]      pend_q, pend_d;
  logic [1:0][8:0] addr_q, addr_d;
  logic [1:0][7:0] wdata_q, wdata_d;
  logic [1:0]      op_wr_q, op_wr_d;
  logic            last_q, last_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [8:0]      tgt_addr_q, tgt_addr_d;
  logic [7:0]      tgt_wdata_q, tgt_wdata_d;
  logic            tgt_rd_q, tgt_rd_d;
  logic            tgt_wr_q, tgt_wr_d;
  logic [1:0][7:0] rdata_q, rdata_d;
  logic [1:0]      ack_q, ack_d;
  logic            tout_q, tout_d;
  logic            done;
  logic            win;

  assign in_addr[0]  = bus.req0_addr;
  assign in_addr[1]  = bus.req1_addr;
  assign in_wdata[0] = bus.req0_wdata;
  assign in_wdata[1] = bus.req1_wdata;
  assign in_rd[0]    = bus.req0_read;
  assign in_rd[1]    = bus.req1_read;
  assign in_wr[0]    = bus.req0_write;
  assign in_wr[1]    = bus.req1_write;

  // last_q doubles as the granted port while in WAIT.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    tgt_addr_d  = tgt_addr_q;
    tgt_wdata_d = tgt_wdata_q;
    tgt_rd_d    = 1'b0;
    tgt_wr_d    = 1'b0;
    rdata_d     = rdata_q;
    ack_d       = 2'b00;
    tout_d      = tout_q & ~bus.err_clr;
    done        = 1'b0;
    win         = 1'b0;
    case (state_q)
      IDLE: begin
        if (|pend_q) begin
          win         = (&pend_q) ? ~last_q : pend_q[1];
          last_d      = win;
          cnt_d       = '0;
          tgt_addr_d  = addr_q[win];
          tgt_wdata_d = wdata_q[win];
          tgt_wr_d    = op_wr_q[win];
          tgt_rd_d    = ~op_wr_q[win];
          state_d     = WAIT;
        end
      end
      WAIT: begin
        // A real ack in the timeout cycle takes precedence over the timeout.
        if (bus.tgt_ack || (cnt_q == TMO)) begin
          done          = 1'b1;
          ack_d[last_q] = 1'b1;
          cnt_d         = '0;
          state_d       = IDLE;
          if (bus.tgt_ack) begin
            rdata_d[last_q] = op_wr_q[last_q] ? 8'h00 : bus.tgt_rdata;
          end else begin
            rdata_d[last_q] = 8'hFF;
            tout_d          = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pend_d  = pend_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    op_wr_d = op_wr_q;
    for (int i = 0; i < 2; i++) begin
      if (done && (last_q == 1'(i))) begin
        pend_d[i] = 1'b0;
      end
      if (!pend_q[i] && (in_rd[i] || in_wr[i])) begin
        pend_d[i]  = 1'b1;
        addr_d[i]  = in_addr[i];
        wdata_d[i] = in_wdata[i];
        op_wr_d[i] = in_wr[i];
      end
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= IDLE;
      pend_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      op_wr_q     <= '0;
      last_q      <= 1'b1;
      cnt_q       <= '0;
      tgt_addr_q  <= '0;
      tgt_wdata_q <= '0;
      tgt_rd_q    <= 1'b0;
      tgt_wr_q    <= 1'b0;
      rdata_q     <= '0;
      ack_q       <= '0;
      tout_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      op_wr_q     <= op_wr_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      tgt_addr_q  <= tgt_addr_d;
      tgt_wdata_q <= tgt_wdata_d;
      tgt_rd_q    <= tgt_rd_d;
      tgt_wr_q    <= tgt_wr_d;
      rdata_q     <= rdata_d;
      ack_q       <= ack_d;
      tout_q      <= tout_d;
    end
  end

  assign bus.req0_rdata = rdata_q[0];
  assign bus.req1_rdata = rdata_q[1];
  assign bus.req0_ack   = ack_q[0];
  assign bus.req1_ack   = ack_q[1];
  assign bus.tgt_addr   = tgt_addr_q;
  assign bus.tgt_wdata  = tgt_wdata_q;
  assign bus.tgt_read   = tgt_rd_q;
  assign bus.tgt_write  = tgt_wr_q;
  assign bus.tout_err   = tout_q;
endmodule
